// File: rtl/ram_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_pkg
// Brief    : Shared FSM encoding and read-latency limits for the RAM scanner.
// Revision : 1.0  initial release
// ============================================================================
package ram_scan_pkg;

    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Keeps an out-of-range read latency from building a zero- or over-length pipe
    function automatic int clamp_lat(input int lat);
        if (lat < 1) begin
            return 1;
        end else if (lat > RD_LAT_MAX) begin
            return RD_LAT_MAX;
        end else begin
            return lat;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_if
// Brief    : RAM read port between the scanner (master) and the BRAM (slave).
// Revision : 1.0  initial release
// ============================================================================
interface ram_scan_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic [DATA_W-1:0] ram_data;

    modport master (output ram_addr, output ram_en, input ram_data);
    modport slave  (input ram_addr, input ram_en, output ram_data);
endinterface
`default_nettype wire

// File: rtl/ram_scan_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_tag_pipe
// Brief    : RD_LAT-deep {valid, last} shift register with synchronous flush.
// Revision : 1.0  initial release
// ============================================================================
module ram_scan_tag_pipe #(
    parameter int RD_LAT = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_flush,
    input  wire logic i_valid,
    input  wire logic i_last,
    output logic      o_valid,
    output logic      o_last,
    output logic      o_any
);
    logic [RD_LAT-1:0] r_valid;
    logic [RD_LAT-1:0] r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_last  <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
            r_last  <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_last[0]  <= i_valid & i_last;
            for (int k = 1; k < RD_LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_last[k]  <= r_last[k-1];
            end
        end
    end

    assign o_valid = r_valid[RD_LAT-1];
    assign o_last  = r_last[RD_LAT-1];
    assign o_any   = |r_valid;
endmodule
`default_nettype wire

// File: rtl/ram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_reader
// Brief    : Scans a BRAM window (base, length, wrap) into a valid/last stream
//            with abort and done pulse. Define RAM_SCAN_SUM_EN to add o_sum.
// Revision : 1.0  initial release
// ============================================================================
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12,
    parameter int LEN_W  = 11,
    parameter int RD_LAT = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_start,
    input  wire logic              i_abort,
    input  wire logic [ADDR_W-1:0] i_base_addr,
    input  wire logic [LEN_W-1:0]  i_length,
    ram_scan_if.master             ram_bus,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_data_valid,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_done
`ifdef RAM_SCAN_SUM_EN
    ,
    output logic [DATA_W+LEN_W-1:0] o_sum
`endif
);
    localparam int c_LAT = clamp_lat(RD_LAT);

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_data;
    logic              r_data_valid;
    logic              r_last;

    logic w_issue;
    logic w_flush;
    logic w_issue_last;
    logic w_tag_valid;
    logic w_tag_last;
    logic w_tag_any;

    assign w_issue      = (r_state == ST_ISSUE);
    assign w_flush      = i_abort && (w_issue || (r_state == ST_DRAIN));
    assign w_issue_last = (r_cnt == r_len - LEN_W'(1));

    // Abort must kill the read in the very cycle it arrives, hence the ungated path
    assign ram_bus.ram_en   = w_issue && !i_abort;
    assign ram_bus.ram_addr = r_base + ADDR_W'(r_cnt);

    ram_scan_tag_pipe #(
        .RD_LAT (c_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_valid (ram_bus.ram_en),
        .i_last  (w_issue_last),
        .o_valid (w_tag_valid),
        .o_last  (w_tag_last),
        .o_any   (w_tag_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_base  <= i_base_addr;
                        r_len   <= i_length;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (i_length != '0) ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (i_abort) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_issue_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_abort || !w_tag_any) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_data_valid <= w_tag_valid && !w_flush;
            r_last       <= w_tag_valid && w_tag_last && !w_flush;
            if (w_tag_valid) begin
                r_data <= ram_bus.ram_data;
            end
        end
    end

`ifdef RAM_SCAN_SUM_EN
    logic [DATA_W+LEN_W-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_sum <= '0;
        end else if (r_data_valid) begin
            r_sum <= r_sum + (DATA_W+LEN_W)'(r_data);
        end
    end

    assign o_sum = r_sum;
`endif

    assign o_data       = r_data;
    assign o_data_valid = r_data_valid;
    assign o_last       = r_last;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_ram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_scan_reader
// Brief    : Directed table-driven bench for ram_scan_reader plus latency sweep.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_scan_reader;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_abort;
    logic        sw_start;
    logic [9:0]  i_base_addr;
    logic [10:0] i_length;
    logic [11:0] o_data;
    logic        o_data_valid;
    logic        o_last;
    logic        o_busy;
    logic        o_done;
`ifdef RAM_SCAN_SUM_EN
    logic [22:0] o_sum;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    ram_scan_if #(.ADDR_W(10), .DATA_W(12)) bus ();

    ram_scan_reader #(
        .ADDR_W (10),
        .DATA_W (12),
        .LEN_W  (11),
        .RD_LAT (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_base_addr  (i_base_addr),
        .i_length     (i_length),
        .ram_bus      (bus),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
`ifdef RAM_SCAN_SUM_EN
        ,
        .o_sum        (o_sum)
`endif
    );

    // RAM model: data equals address, two-cycle read latency
    logic [9:0] ram_pipe [2];
    always @(posedge clk) begin
        ram_pipe[0] <= bus.ram_addr;
        ram_pipe[1] <= ram_pipe[0];
    end
    assign bus.ram_data = {2'b00, ram_pipe[1]};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        ram_scan_if #(.ADDR_W(10), .DATA_W(12)) sbus ();
        logic [11:0] dd;
        logic        dv;
        logic        dl;
        logic        db;
        logic        dn;
        logic [9:0]  pipe [LAT];
        int fe  = -1;
        int fv  = -1;
        int nv  = 0;
        int nl  = 0;
        int nd  = 0;
        int bad = 0;
`ifdef RAM_SCAN_SUM_EN
        logic [22:0] ssum;
`endif
        ram_scan_reader #(
            .ADDR_W (10),
            .DATA_W (12),
            .LEN_W  (11),
            .RD_LAT (LAT)
        ) u_sw (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_start      (sw_start),
            .i_abort      (1'b0),
            .i_base_addr  (i_base_addr),
            .i_length     (i_length),
            .ram_bus      (sbus),
            .o_data       (dd),
            .o_data_valid (dv),
            .o_last       (dl),
            .o_busy       (db),
            .o_done       (dn)
`ifdef RAM_SCAN_SUM_EN
            ,
            .o_sum        (ssum)
`endif
        );
        always @(posedge clk) begin
            pipe[0] <= sbus.ram_addr;
            for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
        end
        assign sbus.ram_data = {2'b00, pipe[LAT-1]};
        always @(negedge clk) begin
            if (sbus.ram_en && fe < 0) fe <= cyc;
            if (dv) begin
                if (fv < 0) fv <= cyc;
                if (int'(dd) != nv) bad <= bad + 1;
                nv <= nv + 1;
                if (dl) nl <= nl + 1;
            end
            if (dn) nd <= nd + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Per-run observations gathered by run_scan
    int n_en, n_valid, n_last, last_idx, n_done, first_valid, last_valid, done_cyc;
    int n_busy, seq_err, gap, last_data, valid_after_abort, en_at_abort, en_after_rst, timeout;

    task automatic run_scan(input int base, input int len, input int abort_at,
                            input int rst_at, input int restart_at);
        logic [9:0] base_v;
        base_v = 10'(base);
        n_en = 0; n_valid = 0; n_last = 0; last_idx = -1; n_done = 0;
        first_valid = -1; last_valid = -1; done_cyc = -1; n_busy = 0; seq_err = 0;
        gap = 0; last_data = -1; valid_after_abort = 0; en_at_abort = 0;
        en_after_rst = 0; timeout = 1;
        i_base_addr = base_v;
        i_length    = 11'(len);
        i_start     = 1'b1;
        i_abort     = (abort_at == 0);
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            i_start     = (k == restart_at);
            i_abort     = (k == abort_at);
            i_base_addr = (k == restart_at) ? 10'd500 : ~base_v;
            i_length    = (k == restart_at) ? 11'd3 : 11'd7;
            if (rst_at > 0 && k == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_ram_en", int'(bus.ram_en), 0);
                check("rst_ram_addr", int'(bus.ram_addr), 0);
                check("rst_valid_last", int'({o_data_valid, o_last}), 0);
                check("rst_data", int'(o_data), 0);
                check("rst_busy_done", int'({o_busy, o_done}), 0);
`ifdef RAM_SCAN_SUM_EN
                check("rst_sum", int'(o_sum), 0);
`endif
            end
            if (rst_at > 0 && k == rst_at + 2) rst_n = 1'b1;
            #1;
            if (bus.ram_en) begin
                if (int'(bus.ram_addr) != (base + n_en) % 1024) seq_err++;
                if (rst_at > 0 && k > rst_at) en_after_rst++;
                n_en++;
            end
            if (k == abort_at) en_at_abort = int'(bus.ram_en);
            if (o_data_valid) begin
                if (int'(o_data) != (base + n_valid) % 1024) seq_err++;
                if (first_valid < 0) first_valid = k;
                else if (k != last_valid + 1) gap++;
                if (o_last) begin
                    n_last++;
                    last_idx = n_valid;
                end
                if (abort_at > 0 && k > abort_at) valid_after_abort++;
                last_valid = k;
                last_data  = int'(o_data);
                n_valid++;
            end
            if (o_busy) n_busy++;
            if (o_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (rst_at < 0 && done_cyc >= 0 && k >= done_cyc + 3) begin
                timeout = 0;
                break;
            end
            if (rst_at > 0 && k == rst_at + 6) begin
                timeout = 0;
                break;
            end
        end
        i_abort = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic sweep_check(input int lat, input int fe, input int fv, input int nv,
                               input int nl, input int nd, input int bad, input int sum);
        check($sformatf("sweep%0d_latency", lat), fv - fe, lat + 1);
        check($sformatf("sweep%0d_words", lat), nv, 16);
        check($sformatf("sweep%0d_data", lat), bad, 0);
        check($sformatf("sweep%0d_last", lat), nl, 1);
        check($sformatf("sweep%0d_done", lat), nd, 1);
`ifdef RAM_SCAN_SUM_EN
        check($sformatf("sweep%0d_sum", lat), sum, 120);
`else
        if (sum != 0) $display("sweep%0d sum tap unexpectedly driven", lat);
`endif
    endtask

    typedef struct {
        int base; int len; int abort_at;
        int exp_en; int exp_valid; int exp_first_valid; int exp_final;
        int exp_last; int exp_last_idx; int exp_done; int exp_busy; int exp_sum;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // base len abort | en valid first_valid final last last_idx done busy sum
        vecs[0] = '{0,    576, -1, 576, 576,  4, 575, 1, 575, 581, 580, 165600};
        vecs[1] = '{1020,   8, -1,   8,   8,  4,   3, 1,   7,  13,  12,   4092};
        vecs[2] = '{5,      0, -1,   0,   0, -1,  -1, 0,  -1,   2,   1,      0};
        vecs[3] = '{10,   100,  5,   4,   2,  4,  11, 0,  -1,   7,   6,     21};
        vecs[4] = '{0,     16, -1,  16,  16,  4,  15, 1,  15,  21,  20,    120};
        vecs[5] = '{1000,   1, -1,   1,   1,  4,1000, 1,   0,   6,   5,   1000};
        vecs[6] = '{3,      4,  0,   4,   4,  4,   6, 1,   3,   9,   8,     18};

        rst_n = 1'b1; i_start = 1'b0; i_abort = 1'b0; sw_start = 1'b0;
        i_base_addr = '0; i_length = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_bus", int'({bus.ram_en, bus.ram_addr}), 0);
        check("reset_flags", int'({o_data_valid, o_last, o_busy, o_done}), 0);
        check("reset_data", int'(o_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_scan(vecs[i].base, vecs[i].len, vecs[i].abort_at, -1, -1);
            check($sformatf("v%0d_timeout", i), timeout, 0);
            check($sformatf("v%0d_en_count", i), n_en, vecs[i].exp_en);
            check($sformatf("v%0d_valid_count", i), n_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_sequence", i), seq_err, 0);
            check($sformatf("v%0d_gaps", i), gap, 0);
            check($sformatf("v%0d_first_valid", i), first_valid, vecs[i].exp_first_valid);
            check($sformatf("v%0d_final_word", i), last_data, vecs[i].exp_final);
            check($sformatf("v%0d_last_count", i), n_last, vecs[i].exp_last);
            check($sformatf("v%0d_last_index", i), last_idx, vecs[i].exp_last_idx);
            check($sformatf("v%0d_done_count", i), n_done, 1);
            check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
            check($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].exp_busy);
            if (vecs[i].abort_at > 0) begin
                check($sformatf("v%0d_en_in_abort", i), en_at_abort, 0);
                check($sformatf("v%0d_valid_after_abort", i), valid_after_abort, 0);
            end
`ifdef RAM_SCAN_SUM_EN
            check($sformatf("v%0d_sum", i), int'(o_sum), vecs[i].exp_sum);
`endif
        end

        // Second start mid-scan, with different base/length, must be ignored
        run_scan(0, 20, -1, -1, 6);
        check("restart_timeout", timeout, 0);
        check("restart_en_count", n_en, 20);
        check("restart_valid_count", n_valid, 20);
        check("restart_sequence", seq_err, 0);
        check("restart_done_cycle", done_cyc, 25);
        check("restart_done_count", n_done, 1);

        // Asynchronous reset mid-scan: outputs drop at once, no done afterwards
        run_scan(0, 50, -1, 10, -1);
        check("rstmid_timeout", timeout, 0);
        check("rstmid_done_count", n_done, 0);
        check("rstmid_en_after", en_after_rst, 0);
        check("rstmid_idle_busy", int'(o_busy), 0);

        // Latency sweep on the RD_LAT=1/3/4 instances
        @(negedge clk);
        i_base_addr = 10'd0;
        i_length    = 11'd16;
        sw_start    = 1'b1;
        @(negedge clk);
        sw_start    = 1'b0;
        repeat (40) @(negedge clk);
`ifdef RAM_SCAN_SUM_EN
        sweep_check(1, g_sweep[0].fe, g_sweep[0].fv, g_sweep[0].nv, g_sweep[0].nl,
                    g_sweep[0].nd, g_sweep[0].bad, int'(g_sweep[0].ssum));
        sweep_check(3, g_sweep[1].fe, g_sweep[1].fv, g_sweep[1].nv, g_sweep[1].nl,
                    g_sweep[1].nd, g_sweep[1].bad, int'(g_sweep[1].ssum));
        sweep_check(4, g_sweep[2].fe, g_sweep[2].fv, g_sweep[2].nv, g_sweep[2].nl,
                    g_sweep[2].nd, g_sweep[2].bad, int'(g_sweep[2].ssum));
`else
        sweep_check(1, g_sweep[0].fe, g_sweep[0].fv, g_sweep[0].nv, g_sweep[0].nl,
                    g_sweep[0].nd, g_sweep[0].bad, 0);
        sweep_check(3, g_sweep[1].fe, g_sweep[1].fv, g_sweep[1].nv, g_sweep[1].nl,
                    g_sweep[1].nd, g_sweep[1].bad, 0);
        sweep_check(4, g_sweep[2].fe, g_sweep[2].fv, g_sweep[2].nv, g_sweep[2].nl,
                    g_sweep[2].nd, g_sweep[2].bad, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
